// File: rtl/comparator_serial.sv
// comparator_serial: bit-serial magnitude comparator, MSB first, one bit per clock.
// Stops at the first differing bit, so latency depends on the operands (worst case WIDTH).
// Optional build macro COMPARATOR_SERIAL_SIGNED_EN adds input signed_md, which selects
// a two's complement comparison; without it the comparison is unsigned only.
//
// state   | meaning
// ST_IDLE | waiting for start; lt/eq/gt hold the last result
// ST_RUN  | comparing captured operands at r_idx, counting down toward bit 0
module comparator_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMPARATOR_SERIAL_SIGNED_EN
  input  logic             signed_md,
`endif
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int            IW      = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_lt;
  logic             r_eq;
  logic             r_gt;

  logic w_a_bit;
  logic w_b_bit;
  logic w_diff;
  logic w_msb_flip;
  logic w_a_wins;

`ifdef COMPARATOR_SERIAL_SIGNED_EN
  logic r_signed;

  // In signed mode a set MSB means negative, so the winner at the MSB is inverted.
  assign w_msb_flip = r_signed && (r_idx == IDX_MSB);
`else
  assign w_msb_flip = 1'b0;
`endif

  assign w_a_bit  = r_a[r_idx];
  assign w_b_bit  = r_b[r_idx];
  assign w_diff   = w_a_bit ^ w_b_bit;
  assign w_a_wins = w_a_bit ^ w_msb_flip;

  // Control FSM: capture on start, scan bits, register result and one-cycle done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
`ifdef COMPARATOR_SERIAL_SIGNED_EN
            r_signed <= signed_md;
`endif
            r_idx   <= IDX_MSB;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_diff) begin
            r_gt    <= w_a_wins;
            r_lt    <= ~w_a_wins;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_idx == '0) begin
            r_eq    <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign lt   = r_lt;
  assign eq   = r_eq;
  assign gt   = r_gt;

endmodule

// File: tb/tb_comparator_serial.sv
// tb_comparator_serial: directed and randomized checks of comparator_serial (WIDTH=8)
// against an arithmetic reference model of latency and result.
module tb_comparator_serial;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         lt;
  logic         eq;
  logic         gt;
`ifdef COMPARATOR_SERIAL_SIGNED_EN
  logic         signed_md;
`endif

  int checks   = 0;
  int failures = 0;

  comparator_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef COMPARATOR_SERIAL_SIGNED_EN
    .signed_md (signed_md),
`endif
    .busy      (busy),
    .done      (done),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: latency from the highest differing bit, result from plain arithmetic.
  // res is {lt,eq,gt}.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic sg,
                       output int k, output logic [2:0] res);
    logic [W-1:0] x;
    int           h;
    logic         a_gt;
    x = ma ^ mb;
    h = -1;
    for (int i = 0; i < W; i++) if (x[i]) h = i;
    if (h < 0) begin
      k   = W;
      res = 3'b010;
    end else begin
      k = W - h;
      if (sg) a_gt = ($signed(ma) > $signed(mb));
      else    a_gt = (ma > mb);
      res = a_gt ? 3'b001 : 3'b100;
    end
  endtask

  // Issue one comparison from the current (idle or done) cycle. inj >= 1 raises a
  // stray start with random operands in RUN cycle inj+1.
  task automatic run_cmp(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic sg,
                         input int inj, input string tag);
    int         k;
    int         cyc;
    int         bcnt;
    logic       seen;
    logic       sg_eff;
    logic [2:0] er;
`ifdef COMPARATOR_SERIAL_SIGNED_EN
    sg_eff    = sg;
    signed_md = sg;
`else
    sg_eff = 1'b0;
`endif
    model(ra, rb, sg_eff, k, er);
    a     = ra;
    b     = rb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
`ifdef COMPARATOR_SERIAL_SIGNED_EN
    signed_md = ~sg;
`endif
    chk({tag, "_accept"}, int'({busy, done, lt, eq, gt}), int'(5'b10000));
    bcnt = 1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < W + 3) begin
      if (inj > 0 && cyc == inj) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, cyc, k);
    chk({tag, "_busy_cycles"}, bcnt, k);
    chk({tag, "_result"}, int'({busy, done, lt, eq, gt}), int'({2'b01, er}));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         sg;
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
`ifdef COMPARATOR_SERIAL_SIGNED_EN
    signed_md = 1'b0;
`endif

    // Reset with start asserted: reset wins.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'({busy, done, lt, eq, gt}), 0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", int'({busy, done, lt, eq, gt}), 0);

    // Early termination at bit 2.
    run_cmp(8'h96, 8'h93, 1'b0, -1, "gt_bit2");
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);

    // Equal operands: full scan, result held afterwards.
    run_cmp(8'h5A, 8'h5A, 1'b0, -1, "eq_full");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("eq_hold", int'({busy, done, lt, eq, gt}), int'(5'b00010));
    end

    // MSB difference: 1-cycle latency, unsigned then signed.
    run_cmp(8'h80, 8'h01, 1'b0, -1, "msb_unsigned");
    @(posedge clk); #1;
`ifdef COMPARATOR_SERIAL_SIGNED_EN
    run_cmp(8'h80, 8'h01, 1'b1, -1, "msb_signed");
    @(posedge clk); #1;
    run_cmp(8'h7F, 8'hFF, 1'b1, -1, "signed_pos_neg");
    @(posedge clk); #1;
`endif

    // Stray start during RUN must not disturb the captured operands.
    run_cmp(8'h00, 8'h01, 1'b0, 1, "ignore_start");
    @(posedge clk); #1;

    // Reset in the 3rd RUN cycle aborts without done.
    a     = 8'h33;
    b     = 8'h33;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", int'({busy, done, lt, eq, gt}), 0);
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(posedge clk); #1;
      chk("abort_quiet", int'({busy, done, lt, eq, gt}), 0);
    end
    run_cmp(8'h10, 8'h08, 1'b0, -1, "after_abort");

    // Back-to-back: start raised in the done cycle of the previous comparison.
    run_cmp(8'h01, 8'h02, 1'b0, -1, "b2b");
    run_cmp(8'hC3, 8'hC3, 1'b0, -1, "b2b_second");

    // Randomized comparisons, mixed back-to-back and idle gaps.
    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom);
      case ($urandom_range(2, 0))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(W - 1, 0));
        default: rb = W'($urandom);
      endcase
      sg = 1'($urandom_range(1, 0));
      run_cmp(ra, rb, sg, ($urandom_range(3, 0) == 0) ? 1 : -1, "random");
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparator_serial.md
COMPARATOR_SERIAL -- requirements
Module: comparator_serial

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits; legal range 2..64.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 SHALL have port: start  input  1  request to begin a comparison of a and b.
REQ-005 SHALL have port: a  input  WIDTH  operand A, sampled only when start is accepted.
REQ-006 SHALL have port: b  input  WIDTH  operand B, sampled only when start is accepted.
REQ-007 SHALL have port: busy  output  1  comparison in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse marking that lt/eq/gt are valid.
REQ-009 SHALL have ports: lt, eq, gt  output  1 each  registered result for A<B, A==B, A>B.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (busy=0) and RUN (busy=1).
REQ-011 SHALL accept start only in IDLE. On acceptance at that clock edge: capture a and b into internal registers, load bit index WIDTH-1, clear lt/eq/gt to 0, and enter RUN.
REQ-012 SHALL ignore start while in RUN, with no effect on the captured operands or the index.
REQ-013 SHALL, on each clock edge in RUN, compare the captured bits at the current index, one bit per cycle, working from MSB to LSB.
REQ-014 SHALL terminate early at the first differing bit: set gt if A bit=1 and B bit=0, otherwise set lt, pulse done, and return to IDLE on the same edge.
REQ-015 SHALL, when index 0 is reached with all bits equal, set eq, pulse done, and return to IDLE.
REQ-016 SHALL give a latency of k clock edges after the accepting edge, where k = (WIDTH-1 - highest differing bit index) + 1, or k = WIDTH when A==B; the worst case is WIDTH.
REQ-017 SHALL hold done high for exactly one cycle; start may be accepted in that same cycle (back-to-back operation).
REQ-018 SHALL hold lt/eq/gt stable after done until the next accepted start; exactly one of the three SHALL be 1 whenever done=1.
REQ-019 SHALL use an index counter of width $clog2(WIDTH), and the index SHALL never wrap below 0.

Reset
REQ-020 SHALL, while rst=1 at a clock edge: force state IDLE and busy=0, done=0, lt=0, eq=0, gt=0; rst SHALL take priority over start.
REQ-021 SHALL abort any RUN in progress when rst is asserted mid-comparison, with no done pulse; after reset releases, the next start SHALL begin a fresh comparison.

Configuration
REQ-022 SHALL recognise the macro COMPARATOR_SERIAL_SIGNED_EN; when it is defined, the module SHALL add port signed_md  input  1, sampled together with a and b when start is accepted.
REQ-023 SHALL, with the macro defined and signed_md=1, treat operands as two's complement: a difference at bit WIDTH-1 SHALL set lt if A's MSB=1 and gt if B's MSB=1; lower bits SHALL use the unsigned rule.
REQ-024 SHALL, without the macro, omit port signed_md and perform an unsigned comparison only.

Verification (WIDTH=8)
REQ-025 SHALL cover: A=0x96, B=0x93, start -> busy for 6 cycles; done on the 6th edge with gt=1, lt=0, eq=0.
REQ-026 SHALL cover: A=B=0x5A -> done on the 8th edge with eq=1; results held until the next start.
REQ-027 SHALL cover: A=0x80, B=0x01 unsigned -> done on the 1st edge with gt=1; with the macro defined and signed_md=1 -> done on the 1st edge with lt=1.
REQ-028 SHALL cover: start pulsed with new operands on the 2nd RUN cycle of A=0x00, B=0x01 -> ignored; done on the 8th edge with lt=1 for the original operands.
REQ-029 SHALL cover: rst asserted on the 3rd RUN cycle -> next edge busy=0, done=0, lt=eq=gt=0, no done pulse; a fresh start of A=0x10, B=0x08 -> done on the 4th edge with gt=1.
REQ-030 SHALL cover: start held high during the done cycle with A=0x01, B=0x02 -> accepted back-to-back; done on the 7th edge with lt=1.
